// File: rtl/fft_seq_ctrl_if.sv
// fft_seq_ctrl_if: handshake and address bundle between the FFT sequencer
// and its surroundings (sample source/sink, data RAM, twiddle ROM, butterfly).
//   start, in_valid, out_ready   : control inputs to the sequencer
//   busy, done                   : transform status
//   ld_we, ld_addr               : bit-reversed sample write port
//   bf_valid, bf_addr_a/b, bf_tw, bf_stage : butterfly issue
//   ul_re, ul_addr               : natural-order result read port
// master = environment side, slave = sequencer side.
interface fft_seq_ctrl_if #(
  parameter int LOG2N = 4
);
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  logic             start;
  logic             in_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             ld_we;
  logic [LOG2N-1:0] ld_addr;
  logic             bf_valid;
  logic [LOG2N-1:0] bf_addr_a;
  logic [LOG2N-1:0] bf_addr_b;
  logic [LOG2N-2:0] bf_tw;
  logic [SW-1:0]    bf_stage;
  logic             ul_re;
  logic [LOG2N-1:0] ul_addr;

  modport master (
    output start, in_valid, out_ready,
    input  busy, done, ld_we, ld_addr, bf_valid, bf_addr_a, bf_addr_b,
           bf_tw, bf_stage, ul_re, ul_addr
  );

  modport slave (
    input  start, in_valid, out_ready,
    output busy, done, ld_we, ld_addr, bf_valid, bf_addr_a, bf_addr_b,
           bf_tw, bf_stage, ul_re, ul_addr
  );
endinterface

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: sequencer for an in-place radix-2 DIT FFT of N = 2^LOG2N
// points held in a dual-port RAM. Loads samples in bit-reversed order,
// issues one butterfly per cycle per stage with a BF_LAT-cycle drain gap
// between stages, then reads results out in natural order.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset, abandons any transform
//   bus  : fft_seq_ctrl_if.slave (see interface header for signal roles)
//
// state  | meaning
// IDLE   | waiting for start; counters cleared
// LOAD   | accepting N samples, writing to bitrev(count)
// COMP   | issuing butterfly j of stage s, one per cycle
// DRAIN  | BF_LAT idle cycles letting the butterfly pipeline retire
// UNLOAD | presenting natural-order read addresses under out_ready
module fft_seq_ctrl #(
  parameter int LOG2N  = 4,
  parameter int BF_LAT = 2
) (
  input logic          CLK,
  input logic          RST,
  fft_seq_ctrl_if.slave bus
);
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
  localparam logic [LOG2N-1:0] LAST_N = '1;
  localparam logic [LOG2N-2:0] LAST_J = '1;
  localparam logic [SW-1:0]    LAST_S = SW'(LOG2N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMP, DRAIN, UNLOAD} state_t;

  typedef struct packed {
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    logic [LOG2N-2:0] tw;
  } bf_t;

  state_t           state;
  logic [LOG2N-1:0] ld_cnt;
  logic [LOG2N-2:0] bf_j;
  logic [3:0]       drn_tmr;
  logic             busy_q;
  logic             done_q;
  logic             bf_valid_q;
  logic [LOG2N-1:0] bf_a_q;
  logic [LOG2N-1:0] bf_b_q;
  logic [LOG2N-2:0] bf_tw_q;
  logic [SW-1:0]    bf_stage_q;
  logic             ul_re_q;
  logic [LOG2N-1:0] ul_addr_q;

  logic [SW-1:0]    nxt_s;
  logic [LOG2N-2:0] nxt_j;
  bf_t              nxt_bf;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Inserting a zero at bit s of j splits it into group (above) and
  // position (below): that is grp*2^(s+1) + pos without a multiplier.
  // The lower leg is the same address with bit s set.
  function automatic bf_t bf_calc(input logic [SW-1:0] s, input logic [LOG2N-2:0] j);
    logic [LOG2N-1:0] jj, span, mask, tw_full;
    logic [SW-1:0]    sh;
    bf_t              r;
    jj      = {1'b0, j};
    span    = ONE << s;
    mask    = span - ONE;
    sh      = LAST_S - s;
    tw_full = (jj & mask) << sh;
    r.a     = ((jj & ~mask) << 1) | (jj & mask);
    r.b     = r.a | span;
    r.tw    = tw_full[LOG2N-2:0];
    return r;
  endfunction

  // Butterfly to present in the next cycle; LOAD (and anything else)
  // falls through to stage 0, j 0.
  always_comb begin
    nxt_s = '0;
    nxt_j = '0;
    if (state == COMP && bf_j != LAST_J) begin
      nxt_s = bf_stage_q;
      nxt_j = bf_j + 1'b1;
    end else if (state == COMP || state == DRAIN) begin
      nxt_s = bf_stage_q + 1'b1;
      nxt_j = '0;
    end
    nxt_bf = bf_calc(nxt_s, nxt_j);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      ld_cnt     <= '0;
      bf_j       <= '0;
      drn_tmr    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      bf_a_q     <= '0;
      bf_b_q     <= '0;
      bf_tw_q    <= '0;
      bf_stage_q <= '0;
      ul_re_q    <= 1'b0;
      ul_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          ld_cnt     <= '0;
          bf_j       <= '0;
          bf_stage_q <= '0;
          ul_addr_q  <= '0;
          if (bus.start) begin
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == LAST_N) begin
              state      <= COMP;
              bf_valid_q <= 1'b1;
              bf_a_q     <= nxt_bf.a;
              bf_b_q     <= nxt_bf.b;
              bf_tw_q    <= nxt_bf.tw;
              bf_stage_q <= nxt_s;
              bf_j       <= nxt_j;
            end
          end
        end
        COMP: begin
          if (bf_j == LAST_J && BF_LAT != 0) begin
            state      <= DRAIN;
            bf_valid_q <= 1'b0;
            drn_tmr    <= 4'(BF_LAT - 1);
          end else if (bf_j == LAST_J && bf_stage_q == LAST_S) begin
            state      <= UNLOAD;
            bf_valid_q <= 1'b0;
            ul_re_q    <= 1'b1;
            ul_addr_q  <= '0;
          end else begin
            bf_a_q     <= nxt_bf.a;
            bf_b_q     <= nxt_bf.b;
            bf_tw_q    <= nxt_bf.tw;
            bf_stage_q <= nxt_s;
            bf_j       <= nxt_j;
          end
        end
        DRAIN: begin
          if (drn_tmr != 4'd0) begin
            drn_tmr <= drn_tmr - 1'b1;
          end else if (bf_stage_q == LAST_S) begin
            state     <= UNLOAD;
            ul_re_q   <= 1'b1;
            ul_addr_q <= '0;
          end else begin
            state      <= COMP;
            bf_valid_q <= 1'b1;
            bf_a_q     <= nxt_bf.a;
            bf_b_q     <= nxt_bf.b;
            bf_tw_q    <= nxt_bf.tw;
            bf_stage_q <= nxt_s;
            bf_j       <= nxt_j;
          end
        end
        UNLOAD: begin
          if (bus.out_ready) begin
            if (ul_addr_q == LAST_N) begin
              state     <= IDLE;
              ul_re_q   <= 1'b0;
              ul_addr_q <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              ul_addr_q <= ul_addr_q + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ld_we     = bus.in_valid & (state == LOAD);
  assign bus.ld_addr   = bitrev(ld_cnt);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bf_valid  = bf_valid_q;
  assign bus.bf_addr_a = bf_a_q;
  assign bus.bf_addr_b = bf_b_q;
  assign bus.bf_tw     = bf_tw_q;
  assign bus.bf_stage  = bf_stage_q;
  assign bus.ul_re     = ul_re_q;
  assign bus.ul_addr   = ul_addr_q;
endmodule

// File: tb/tb_fft_seq_ctrl.sv
module tb_fft_seq_ctrl;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_seq_ctrl_if #(.LOG2N(4)) ia ();
  fft_seq_ctrl_if #(.LOG2N(2)) ib ();

  fft_seq_ctrl #(.LOG2N(4), .BF_LAT(2)) dut_a (.CLK(clk), .RST(rst_a), .bus(ia));
  fft_seq_ctrl #(.LOG2N(2), .BF_LAT(0)) dut_b (.CLK(clk), .RST(rst_b), .bus(ib));

  typedef struct {
    int kind;
    int v0;
    int v1;
    int v2;
    int v3;
  } exp_t;

  localparam int K_LD = 0;
  localparam int K_BF = 1;
  localparam int K_UL = 2;
  localparam int K_DN = 3;

  exp_t qa[$];
  exp_t qb[$];
  exp_t seen_a[$];
  int t_start_a, t_last_ld_a, t_first_bf_a, t_first_ul_a, t_done_a, n_bf_a;
  int t_start_b, t_last_ld_b, t_first_bf_b, t_first_ul_b, t_done_b, n_bf_b;

  function automatic exp_t mk(input int k, input int a, input int b, input int c, input int d);
    exp_t e;
    e.kind = k; e.v0 = a; e.v1 = b; e.v2 = c; e.v3 = d;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  task automatic score(input string tag, input int have, input exp_t e, input int k,
                       input int v0, input int v1, input int v2, input int v3);
    if (have == 0) begin
      check({tag, "_unexpected_event"}, k, -1);
    end else begin
      check({tag, "_kind"}, k, e.kind);
      if (k == e.kind) begin
        check({tag, "_v0"}, v0, e.v0);
        if (k == K_BF) begin
          check({tag, "_addr_b"}, v1, e.v1);
          check({tag, "_tw"}, v2, e.v2);
          check({tag, "_stage"}, v3, e.v3);
        end
      end
    end
  endtask

  task automatic pop_a(output int have, output exp_t e);
    e = mk(-1, 0, 0, 0, 0);
    have = int'(qa.size() > 0);
    if (have != 0) e = qa.pop_front();
  endtask

  task automatic pop_b(output int have, output exp_t e);
    e = mk(-1, 0, 0, 0, 0);
    have = int'(qb.size() > 0);
    if (have != 0) e = qb.pop_front();
  endtask

  // Monitors: one event per cycle at most (load, butterfly, unload and done
  // are mutually exclusive), each checked against the head of the queue.
  always @(negedge clk) begin : mon_a
    exp_t e;
    int   have;
    if (!rst_a) begin
      if (ia.ld_we) begin
        t_last_ld_a = cyc;
        pop_a(have, e);
        score("a_ld", have, e, K_LD, int'(ia.ld_addr), 0, 0, 0);
      end
      if (ia.bf_valid) begin
        if (t_first_bf_a < 0) t_first_bf_a = cyc;
        n_bf_a++;
        seen_a.push_back(mk(K_BF, int'(ia.bf_addr_a), int'(ia.bf_addr_b), int'(ia.bf_tw), int'(ia.bf_stage)));
        pop_a(have, e);
        score("a_bf", have, e, K_BF, int'(ia.bf_addr_a), int'(ia.bf_addr_b), int'(ia.bf_tw), int'(ia.bf_stage));
      end
      if (ia.ul_re) begin
        if (t_first_ul_a < 0) t_first_ul_a = cyc;
        if (ia.out_ready) begin
          pop_a(have, e);
          score("a_ul", have, e, K_UL, int'(ia.ul_addr), 0, 0, 0);
        end
      end
      if (ia.done) begin
        t_done_a = cyc;
        check("a_done_excl", int'(ia.bf_valid | ia.ld_we), 0);
        pop_a(have, e);
        score("a_done", have, e, K_DN, int'(ia.busy), 0, 0, 0);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    int   have;
    if (!rst_b) begin
      if (ib.ld_we) begin
        t_last_ld_b = cyc;
        pop_b(have, e);
        score("b_ld", have, e, K_LD, int'(ib.ld_addr), 0, 0, 0);
      end
      if (ib.bf_valid) begin
        if (t_first_bf_b < 0) t_first_bf_b = cyc;
        n_bf_b++;
        pop_b(have, e);
        score("b_bf", have, e, K_BF, int'(ib.bf_addr_a), int'(ib.bf_addr_b), int'(ib.bf_tw), int'(ib.bf_stage));
      end
      if (ib.ul_re) begin
        if (t_first_ul_b < 0) t_first_ul_b = cyc;
        if (ib.out_ready) begin
          pop_b(have, e);
          score("b_ul", have, e, K_UL, int'(ib.ul_addr), 0, 0, 0);
        end
      end
      if (ib.done) begin
        t_done_b = cyc;
        check("b_done_excl", int'(ib.bf_valid | ib.ld_we), 0);
        pop_b(have, e);
        score("b_done", have, e, K_DN, int'(ib.busy), 0, 0, 0);
      end
    end
  end

  task automatic check_zero_a(input string tag);
    check({tag, "_busy"}, int'(ia.busy), 0);
    check({tag, "_done"}, int'(ia.done), 0);
    check({tag, "_ld_we"}, int'(ia.ld_we), 0);
    check({tag, "_ld_addr"}, int'(ia.ld_addr), 0);
    check({tag, "_bf_valid"}, int'(ia.bf_valid), 0);
    check({tag, "_bf_addr_a"}, int'(ia.bf_addr_a), 0);
    check({tag, "_bf_addr_b"}, int'(ia.bf_addr_b), 0);
    check({tag, "_bf_tw"}, int'(ia.bf_tw), 0);
    check({tag, "_bf_stage"}, int'(ia.bf_stage), 0);
    check({tag, "_ul_re"}, int'(ia.ul_re), 0);
    check({tag, "_ul_addr"}, int'(ia.ul_addr), 0);
  endtask

  task automatic check_zero_b(input string tag);
    check({tag, "_busy"}, int'(ib.busy), 0);
    check({tag, "_done"}, int'(ib.done), 0);
    check({tag, "_ld_we"}, int'(ib.ld_we), 0);
    check({tag, "_bf_valid"}, int'(ib.bf_valid), 0);
    check({tag, "_bf_addr_a"}, int'(ib.bf_addr_a), 0);
    check({tag, "_bf_addr_b"}, int'(ib.bf_addr_b), 0);
    check({tag, "_ul_re"}, int'(ib.ul_re), 0);
    check({tag, "_ul_addr"}, int'(ib.ul_addr), 0);
  endtask

  // Expected event stream for one full 16-point transform.
  task automatic push_run_a();
    int ld_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    for (int i = 0; i < 16; i++) qa.push_back(mk(K_LD, ld_tab[i], 0, 0, 0));
    for (int s = 0; s < 4; s++)
      for (int g = 0; g < (8 >> s); g++)
        for (int p = 0; p < (1 << s); p++)
          qa.push_back(mk(K_BF, g * (2 << s) + p, g * (2 << s) + p + (1 << s), p * (8 >> s), s));
    for (int i = 0; i < 16; i++) qa.push_back(mk(K_UL, i, 0, 0, 0));
    qa.push_back(mk(K_DN, 0, 0, 0, 0));
  endtask

  task automatic run_a(input int gap, input bit bp, input bit abort, input string tag);
    int k;
    t_last_ld_a = -1; t_first_bf_a = -1; t_first_ul_a = -1; t_done_a = -1; n_bf_a = 0;
    seen_a.delete();
    qa.delete();
    push_run_a();
    ia.out_ready = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b1;
    t_start_a = cyc;
    @(posedge clk); #1;
    ia.start = 1'b0;
    ia.in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_busy_load"}, int'(ia.busy), 1);
    for (int i = 0; i < 16; i++) begin
      ia.in_valid = 1'b1;
      @(posedge clk); #1;
      if (gap > 0) begin
        ia.in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    if (abort) begin
      k = 0;
      while (!(ia.bf_valid && ia.bf_stage == 2'd2) && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      check({tag, "_reach_stage2"}, int'(ia.bf_valid && ia.bf_stage == 2'd2), 1);
      rst_a = 1'b1;
      @(negedge clk);
      check_zero_a({tag, "_in_rst"});
      @(posedge clk); #1;
      rst_a = 1'b0;
      ia.in_valid = 1'b0;
      qa.delete();
      @(negedge clk);
      check_zero_a({tag, "_after_rst"});
      return;
    end
    if (bp) begin
      k = 0;
      while (!(ia.ul_re && ia.ul_addr == 4'd6) && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      check({tag, "_reach_ul6"}, int'(ia.ul_re && ia.ul_addr == 4'd6), 1);
      ia.out_ready = 1'b0;
      repeat (5) begin
        @(negedge clk);
        check({tag, "_hold_addr"}, int'(ia.ul_addr), 6);
        check({tag, "_hold_re"}, int'(ia.ul_re), 1);
        @(posedge clk); #1;
      end
      ia.out_ready = 1'b1;
    end
    k = 0;
    while (t_done_a < 0 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_done_seen"}, int'(t_done_a >= 0), 1);
    ia.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_idle_busy"}, int'(ia.busy), 0);
    check({tag, "_done_pulse"}, int'(ia.done), 0);
    if (gap == 0 && !bp) check({tag, "_start_to_done"}, t_done_a - t_start_a, 73);
    check({tag, "_comp_len"}, t_first_ul_a - t_first_bf_a, 40);
    check({tag, "_bf_after_ld"}, t_first_bf_a - t_last_ld_a, 1);
    check({tag, "_n_bf"}, n_bf_a, 32);
    check({tag, "_q_left"}, qa.size(), 0);
    check({tag, "_seen_size"}, seen_a.size(), 32);
    if (seen_a.size() == 32) begin
      check({tag, "_s0j3_a"}, seen_a[3].v0, 6);
      check({tag, "_s0j3_b"}, seen_a[3].v1, 7);
      check({tag, "_s0j3_tw"}, seen_a[3].v2, 0);
      check({tag, "_s1j3_a"}, seen_a[11].v0, 5);
      check({tag, "_s1j3_b"}, seen_a[11].v1, 7);
      check({tag, "_s1j3_tw"}, seen_a[11].v2, 4);
      check({tag, "_s3j5_a"}, seen_a[29].v0, 5);
      check({tag, "_s3j5_b"}, seen_a[29].v1, 13);
      check({tag, "_s3j5_tw"}, seen_a[29].v2, 5);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int k;
    int ld_b[4] = '{0, 2, 1, 3};
    rst_a = 1'b1;
    rst_b = 1'b1;
    ia.start = 1'b0; ia.in_valid = 1'b0; ia.out_ready = 1'b0;
    ib.start = 1'b0; ib.in_valid = 1'b0; ib.out_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      ia.in_valid = i[0]; ia.out_ready = ~i[0];
      ib.in_valid = i[0]; ib.out_ready = ~i[0];
    end
    @(negedge clk);
    check_zero_a("a_rst");
    check_zero_b("b_rst");
    @(posedge clk); #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ia.in_valid = i[0]; ia.out_ready = i[1];
      @(negedge clk);
      check("a_idle_busy", int'(ia.busy), 0);
      check("b_idle_busy", int'(ib.busy), 0);
      @(posedge clk); #1;
    end
    #2;
    rst_a = 1'b1;
    @(negedge clk);
    check_zero_a("a_midrst");
    @(posedge clk); #1;
    rst_a = 1'b0;
    ia.in_valid = 1'b0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.out_ready = 1'b0;

    run_a(0, 1'b0, 1'b0, "a_run1");
    run_a(3, 1'b1, 1'b0, "a_run2");
    run_a(0, 1'b0, 1'b1, "a_abort");
    run_a(0, 1'b0, 1'b0, "a_rerun");

    // Smallest legal transform, no drain, plus a start while busy.
    t_last_ld_b = -1; t_first_bf_b = -1; t_first_ul_b = -1; t_done_b = -1; n_bf_b = 0;
    qb.delete();
    for (int i = 0; i < 4; i++) qb.push_back(mk(K_LD, ld_b[i], 0, 0, 0));
    qb.push_back(mk(K_BF, 0, 1, 0, 0));
    qb.push_back(mk(K_BF, 2, 3, 0, 0));
    qb.push_back(mk(K_BF, 0, 2, 0, 1));
    qb.push_back(mk(K_BF, 1, 3, 1, 1));
    for (int i = 0; i < 4; i++) qb.push_back(mk(K_UL, i, 0, 0, 0));
    qb.push_back(mk(K_DN, 0, 0, 0, 0));
    ib.out_ready = 1'b1;
    @(posedge clk); #1;
    ib.start = 1'b1;
    t_start_b = cyc;
    @(posedge clk); #1;
    ib.start = 1'b0;
    ib.in_valid = 1'b1;
    k = 0;
    while (!ib.bf_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("b_bf_seen", int'(ib.bf_valid), 1);
    ib.start = 1'b1;
    @(posedge clk); #1;
    ib.start = 1'b0;
    k = 0;
    while (t_done_b < 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("b_done_seen", int'(t_done_b >= 0), 1);
    ib.in_valid = 1'b0;
    check("b_start_to_done", t_done_b - t_start_b, 13);
    check("b_comp_len", t_first_ul_b - t_first_bf_b, 4);
    check("b_bf_after_ld", t_first_bf_b - t_last_ld_b, 1);
    check("b_n_bf", n_bf_b, 4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b_post_busy", int'(ib.busy), 0);
    end
    check("b_q_left", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
